// File: rtl/rgb565_to_rgb_stream.sv
// rgb565_to_rgb_stream: 2-stage elastic RGB565 to 1-bit RGB decoder with per-line pixel indexing
// and a sticky flag for lines whose length is not LINE_W.
module rgb565_to_rgb_stream #(
    parameter logic [15:0] GRAY     = 16'hD69A,
    parameter logic [4:0]  R_THRESH = 5'd16,
    parameter logic [5:0]  G_THRESH = 6'd32,
    parameter logic [4:0]  B_THRESH = 5'd16,
    parameter int          LINE_W   = 640,
    parameter int          CNT_W    = 10
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [15:0]      iRGB_565,
    input  logic             iLast,
    output logic             oValid,
    input  logic             iReady,
    output logic             oR,
    output logic             oG,
    output logic             oB,
    output logic             oLast,
    output logic [CNT_W-1:0] oPixCnt,
    output logic             oLineErr
);
    logic             s1Valid;
    logic             s1Last;
    logic [15:0]      s1Pix;
    logic [CNT_W-1:0] s1Cnt;
    logic [CNT_W-1:0] pixCnt;
    logic             s2Free;
    logic             inAcc;
    logic             atEnd;
    logic             isGray;
    logic             decR;
    logic             decG;
    logic             decB;
    always_comb begin
        s2Free = !oValid || iReady;
        oReady = !s1Valid || s2Free;
        inAcc  = iValid && oReady;
        atEnd  = pixCnt == CNT_W'(LINE_W - 1);
        isGray = s1Pix == GRAY;
        decR   = isGray || s1Pix[15:11] >= R_THRESH;
        decG   = isGray || s1Pix[10:5] >= G_THRESH;
        decB   = isGray || s1Pix[4:0] >= B_THRESH;
    end
    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1Valid <= 1'b0;
            s1Pix   <= '0;
            s1Last  <= 1'b0;
            s1Cnt   <= '0;
        end else if (oReady) begin
            s1Valid <= iValid;
            if (iValid) begin
                s1Pix  <= iRGB_565;
                s1Last <= iLast;
                s1Cnt  <= pixCnt;
            end
        end
    end
    // Output registers only change when empty or being consumed, keeping them stable under stall.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oValid  <= 1'b0;
            oR      <= 1'b0;
            oG      <= 1'b0;
            oB      <= 1'b0;
            oLast   <= 1'b0;
            oPixCnt <= '0;
        end else if (s2Free) begin
            oValid <= s1Valid;
            if (s1Valid) begin
                oR      <= decR;
                oG      <= decG;
                oB      <= decB;
                oLast   <= s1Last;
                oPixCnt <= s1Cnt;
            end
        end
    end
    // A line is malformed exactly when iLast disagrees with the final-index position.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            pixCnt   <= '0;
            oLineErr <= 1'b0;
        end else if (inAcc) begin
            pixCnt <= (iLast || atEnd) ? '0 : pixCnt + 1'b1;
            if (iLast != atEnd) oLineErr <= 1'b1;
        end
    end
endmodule
